dpram_rr_arbiter: RTL and testbench

- Shares one 256x32 dual-port RAM (one read port, one write port) between two requesters, client A and client B.
- Each port has its own round-robin arbiter. A read and a write can therefore be granted in the same cycle to different clients.
- Routes the RAM's 1-cycle registered read data back to the client that issued the read, with a valid strobe.
- Sits between the two clients and the RAM instance. It holds no storage beyond arbitration and return-tag state.

---
 rtl/dpram_rr_arbiter.sv | 104 ++++++++++
 tb/tb_dpram_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_rr_arbiter.sv
// Two-client front end for a 1R/1W dual-port RAM. Each RAM port has its own
// round-robin arbiter, and a return tag routes the registered read data back.
module dpram_rr_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_data_in
);

  typedef enum logic {
    CLI_A = 1'b0,
    CLI_B = 1'b1
  } client_e;

  client_e rd_pri_q, rd_pri_d;
  client_e wr_pri_q, wr_pri_d;
  client_e rd_who_q, rd_who_d;
  logic    rd_v_q,   rd_v_d;

  logic a_rd, b_rd, a_wq, b_wq;
  logic a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;

  // Requests are masked by rst_n so nothing is granted while reset is held.
  always_comb begin
    a_rd     = rst_n & a_req & ~a_wr;
    b_rd     = rst_n & b_req & ~b_wr;
    a_wq     = rst_n & a_req &  a_wr;
    b_wq     = rst_n & b_req &  b_wr;
    a_rd_gnt = a_rd & (~b_rd | (rd_pri_q == CLI_A));
    b_rd_gnt = b_rd & (~a_rd | (rd_pri_q == CLI_B));
    a_wr_gnt = a_wq & (~b_wq | (wr_pri_q == CLI_A));
    b_wr_gnt = b_wq & (~a_wq | (wr_pri_q == CLI_B));
  end

  always_comb begin
    rd_pri_d = rd_pri_q;
    wr_pri_d = wr_pri_q;
    if (a_rd_gnt)      rd_pri_d = CLI_B;
    else if (b_rd_gnt) rd_pri_d = CLI_A;
    if (a_wr_gnt)      wr_pri_d = CLI_B;
    else if (b_wr_gnt) wr_pri_d = CLI_A;
    rd_v_d   = a_rd_gnt | b_rd_gnt;
    rd_who_d = b_rd_gnt ? CLI_B : CLI_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pri_q <= CLI_A;
      wr_pri_q <= CLI_A;
      rd_who_q <= CLI_A;
      rd_v_q   <= 1'b0;
    end else begin
      rd_pri_q <= rd_pri_d;
      wr_pri_q <= wr_pri_d;
      rd_who_q <= rd_who_d;
      rd_v_q   <= rd_v_d;
    end
  end

  always_comb begin
    a_gnt       = a_rd_gnt | a_wr_gnt;
    b_gnt       = b_rd_gnt | b_wr_gnt;
    ram_rd_en   = a_rd_gnt | b_rd_gnt;
    ram_wr_en   = a_wr_gnt | b_wr_gnt;
    ram_rd_addr = '0;
    ram_wr_addr = '0;
    ram_data_in = '0;
    if (a_rd_gnt)      ram_rd_addr = a_addr;
    else if (b_rd_gnt) ram_rd_addr = b_addr;
    if (a_wr_gnt) begin
      ram_wr_addr = a_addr;
      ram_data_in = a_wdata;
    end else if (b_wr_gnt) begin
      ram_wr_addr = b_addr;
      ram_data_in = b_wdata;
    end
    a_rvalid = rd_v_q & (rd_who_q == CLI_A);
    b_rvalid = rd_v_q & (rd_who_q == CLI_B);
    a_rdata  = a_rvalid ? ram_data_out : '0;
    b_rdata  = b_rvalid ? ram_data_out : '0;
  end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Bench for dpram_rr_arbiter: behavioural RAM plus a port-level arbitration
// model checked every cycle, with directed scenarios carrying literal checks.
module tb_dpram_rr_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_rd_en, ram_wr_en;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [DW-1:0] ram_data_out, ram_data_in;

  always #5 clk = ~clk;

  dpram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in)
  );

  // RAM with registered read port; a same-cycle write lands after the read.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_rd_en) ram_q <= ram_mem[ram_rd_addr];
    if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_data_in;
  end
  assign ram_data_out = ram_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Model state: last winner per port (its rival is preferred next), a
  // shadow memory, and the one outstanding read return (-1 = none).
  logic [DW-1:0] shadow [256];
  int            last_rd = 1, last_wr = 1;
  int            pend_who = -1;
  logic [DW-1:0] pend_data = '0;
  int            n_rd_win = -1, n_wr_win = -1;
  logic [AW-1:0] n_wr_addr = '0;
  logic [DW-1:0] n_wr_data = '0, n_pend_data = '0;

  always @(negedge clk) begin
    bit            ar, br, aw, bw;
    int            rdw, wrw;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    ar = rst_n && a_req && !a_wr;
    br = rst_n && b_req && !b_wr;
    aw = rst_n && a_req && a_wr;
    bw = rst_n && b_req && b_wr;
    rdw = -1;
    if (ar && br) rdw = 1 - last_rd; else if (ar) rdw = 0; else if (br) rdw = 1;
    wrw = -1;
    if (aw && bw) wrw = 1 - last_wr; else if (aw) wrw = 0; else if (bw) wrw = 1;
    ra = (rdw == 0) ? a_addr : (rdw == 1) ? b_addr : 8'd0;
    wa = (wrw == 0) ? a_addr : (wrw == 1) ? b_addr : 8'd0;
    wd = (wrw == 0) ? a_wdata : (wrw == 1) ? b_wdata : 32'd0;
    chk("mdl_a_gnt", a_gnt, (rdw == 0) || (wrw == 0));
    chk("mdl_b_gnt", b_gnt, (rdw == 1) || (wrw == 1));
    chk("mdl_rd_en", ram_rd_en, rdw >= 0);
    chk("mdl_rd_addr", ram_rd_addr, ra);
    chk("mdl_wr_en", ram_wr_en, wrw >= 0);
    chk("mdl_wr_addr", ram_wr_addr, wa);
    chk("mdl_wr_data", ram_data_in, wd);
    chk("mdl_a_rvalid", a_rvalid, pend_who == 0);
    chk("mdl_b_rvalid", b_rvalid, pend_who == 1);
    chk("mdl_a_rdata", a_rdata, (pend_who == 0) ? pend_data : 32'd0);
    chk("mdl_b_rdata", b_rdata, (pend_who == 1) ? pend_data : 32'd0);
    n_rd_win    = rdw;
    n_wr_win    = wrw;
    n_wr_addr   = wa;
    n_wr_data   = wd;
    n_pend_data = (rdw >= 0) ? shadow[ra] : 32'd0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd   <= 1;
      last_wr   <= 1;
      pend_who  <= -1;
      pend_data <= '0;
    end else begin
      if (n_rd_win >= 0) last_rd <= n_rd_win;
      if (n_wr_win >= 0) last_wr <= n_wr_win;
      pend_who  <= n_rd_win;
      pend_data <= n_pend_data;
      if (n_wr_win >= 0) shadow[n_wr_addr] <= n_wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_req = 1'b1; a_wr = 1'b1; a_addr = ad; a_wdata = d;
    @(negedge clk);
    chk("a_wr_gnt", a_gnt, 1);
    step();
    a_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int            k, a_wait;
    bit            a_pending, a_done, ga, gb;
    logic [AW-1:0] ad;
    logic [DW-1:0] ex;

    // Reset then idle
    repeat (3) begin
      @(negedge clk);
      chk("rst_idle", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_rd_en, ram_wr_en}, 0);
    end
    step();
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_rd_en, ram_wr_en}, 0);
    end
    step();

    // Single client write then read
    a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h10; a_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("sw_a_gnt", a_gnt, 1);
    chk("sw_wr_en", ram_wr_en, 1);
    chk("sw_wr_addr", ram_wr_addr, 32'h10);
    step();
    a_wr = 1'b0;
    @(negedge clk);
    chk("sr_a_gnt", a_gnt, 1);
    chk("sr_rd_addr", ram_rd_addr, 32'h10);
    step();
    a_req = 1'b0;
    @(negedge clk);
    chk("sr_a_rvalid", a_rvalid, 1);
    chk("sr_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("sr_b_rvalid", b_rvalid, 0);
    step();

    // Read contention round-robin from a fresh reset
    a_write(8'h01, 32'h0A0A0001);
    a_write(8'h02, 32'h0B0B0002);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h01;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        chk("rr_a_gnt", a_gnt, (i % 2) == 0);
        chk("rr_b_gnt", b_gnt, (i % 2) == 1);
      end
      if (i > 0) begin
        chk("rr_a_rvalid", a_rvalid, ((i - 1) % 2) == 0);
        if (((i - 1) % 2) == 0) chk("rr_a_rdata", a_rdata, 32'h0A0A0001);
        else                    chk("rr_b_rdata", b_rdata, 32'h0B0B0002);
      end
      step();
      if (i == 3) begin a_req = 1'b0; b_req = 1'b0; end
    end

    // Write contention: B streams 8 writes, A injects one write
    k = 0; a_wait = 0; a_pending = 0; a_done = 0;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 8'h40; b_wdata = 32'hB0000000;
    for (int cyc = 0; cyc < 20 && (k < 8 || !a_done); cyc++) begin
      if (cyc == 2) begin
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h80; a_wdata = 32'hA0A0A0A0;
        a_pending = 1;
      end
      @(negedge clk);
      ga = a_gnt; gb = b_gnt;
      if (a_pending) begin
        a_wait++;
        if (ga) begin
          chk("wc_a_within_2", a_wait <= 2, 1);
          a_pending = 0; a_done = 1;
        end else if (a_wait >= 2) begin
          chk("wc_a_within_2", 0, 1);
          a_pending = 0; a_done = 1;
        end
      end
      step();
      if (ga) a_req = 1'b0;
      if (gb) begin
        k++;
        if (k < 8) begin
          b_addr = 8'(8'h40 + k);
          b_wdata = 32'hB0000000 + 32'(k);
        end else b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("wc_b_count", k, 8);
    chk("wc_a_done", a_done, 1);

    // Readback of every written address
    for (int j = 0; j < 9; j++) begin
      ad = (j < 8) ? 8'(8'h40 + j) : 8'h80;
      ex = (j < 8) ? 32'hB0000000 + 32'(j) : 32'hA0A0A0A0;
      a_req = 1'b1; a_wr = 1'b0; a_addr = ad;
      @(negedge clk);
      chk("rb_a_gnt", a_gnt, 1);
      step();
      a_req = 1'b0;
      @(negedge clk);
      chk("rb_a_rdata", a_rdata, ex);
      step();
    end

    // Mixed ports with same-address collision
    a_write(8'h20, 32'h11111111);
    a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h20;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 8'h20; b_wdata = 32'h22222222;
    @(negedge clk);
    chk("col_a_gnt", a_gnt, 1);
    chk("col_b_gnt", b_gnt, 1);
    step();
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("col_old_data", a_rdata, 32'h11111111);
    step();
    a_req = 1'b1;
    @(negedge clk);
    step();
    a_req = 1'b0;
    @(negedge clk);
    chk("col_new_data", a_rdata, 32'h22222222);
    step();

    // Reset asserted between a read grant and its return edge
    b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h02;
    @(negedge clk);
    chk("mr_b_gnt", b_gnt, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_gnt_masked", {b_gnt, ram_rd_en}, 0);
    b_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mr_b_rvalid", b_rvalid, 0);
    end
    step();
    rst_n = 1'b1;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h01;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h02;
    @(negedge clk);
    chk("mr_first_a", a_gnt, 1);
    chk("mr_first_b", b_gnt, 0);
    chk("mr_no_rvalid", b_rvalid, 0);
    step();
    a_req = 1'b0;
    @(negedge clk);
    chk("mr_b_second", b_gnt, 1);
    chk("mr_a_rdata", a_rdata, 32'h0A0A0001);
    step();
    b_req = 1'b0;
    @(negedge clk);
    chk("mr_b_rdata", b_rdata, 32'h0B0B0002);
    step();
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
